// File: rtl/press_arb_pkg.sv
// rtl/press_arb_pkg.sv - shared types, sizes and counter op helper for the press event arbiter
package press_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      INC   = 2'd0,
      DEC   = 2'd1,
      ADD   = 2'd2,
      CLEAR = 2'd3
   } op_e;

   // Next counter value for one op; a 9-bit sum exposes the carry for saturation.
   function automatic logic [CNT_W-1:0] apply_op(
      input op_e              op,
      input logic [CNT_W-1:0] cur,
      input logic [CNT_W-1:0] step,
      input logic             wrap
   );
      logic [CNT_W:0]   sum;
      logic [CNT_W-1:0] res;
      sum = '0;
      res = cur;
      case (op)
         INC: begin
            sum = {1'b0, cur} + {{CNT_W{1'b0}}, 1'b1};
            res = (!wrap && sum[CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
         end
         DEC: begin
            res = (!wrap && cur == '0) ? '0 : cur - {{(CNT_W-1){1'b0}}, 1'b1};
         end
         ADD: begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (!wrap && sum[CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
         end
         CLEAR: begin
            res = '0;
         end
         default: res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational four-way round-robin arbiter starting at ptr
module rr_arbiter4
   import press_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               valid
);

   logic       found;
   logic [1:0] idx;

   // Scan from ptr upward (mod 4); the first pending bit wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (req[idx] && !found) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      valid = found;
   end

endmodule

// File: rtl/press_event_arbiter.sv
// rtl/press_event_arbiter.sv - queues press pulses from four debouncers and applies one counter op per edge
module press_event_arbiter
   import press_arb_pkg::*;
#(
   parameter logic [7:0] STEP = 8'd5,
   parameter int         WRAP = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  press,
   output logic [CNT_W-1:0]    count,
   output logic [NUM_REQ-1:0]  grant,
   output logic                led,
   output logic [7:0]          dropped
);

   logic [NUM_REQ-1:0] pend;
   logic [1:0]         ptr;
   logic [NUM_REQ-1:0] served;
   logic               valid;
   logic [1:0]         win_idx;
   logic [CNT_W-1:0]   count_next;
   logic [NUM_REQ-1:0] drop_bits;
   logic [2:0]         n_drop;
   logic [8:0]         drop_sum;
   logic [7:0]         dropped_next;

   rr_arbiter4 u_arb (
      .req   (pend),
      .ptr   (ptr),
      .gnt   (served),
      .valid (valid)
   );

   always_comb begin
      win_idx = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (served[k]) win_idx = 2'(k);
      end
   end

   assign count_next = apply_op(op_e'(win_idx), count, STEP, (WRAP != 0));

   // A press is lost only if its slot is still pending and not being freed this edge.
   assign drop_bits = press & pend & ~served;

   always_comb begin
      n_drop = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         n_drop = n_drop + {2'b00, drop_bits[k]};
      end
   end

   assign drop_sum     = {1'b0, dropped} + {6'b0, n_drop};
   assign dropped_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= '0;
         ptr     <= 2'd0;
         count   <= '0;
         grant   <= '0;
         led     <= 1'b0;
         dropped <= 8'd0;
      end else begin
         pend    <= (pend & ~served) | press;
         grant   <= served;
         led     <= valid;
         dropped <= dropped_next;
         if (valid) begin
            count <= count_next;
            ptr   <= win_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_press_event_arbiter.sv
// tb/tb_press_event_arbiter.sv - directed self-checking bench for press_event_arbiter (wrap and saturate builds)
module tb_press_event_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] press;
   logic [7:0] count,   count_s;
   logic [3:0] grant,   grant_s;
   logic       led,     led_s;
   logic [7:0] dropped, dropped_s;

   int total = 0;
   int bad   = 0;

   press_event_arbiter #(.STEP(8'd5), .WRAP(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .press   (press),
      .count   (count),
      .grant   (grant),
      .led     (led),
      .dropped (dropped)
   );

   press_event_arbiter #(.STEP(8'd5), .WRAP(0)) dut_sat (
      .clk     (clk),
      .rst     (rst),
      .press   (press),
      .count   (count_s),
      .grant   (grant_s),
      .led     (led_s),
      .dropped (dropped_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      press = 4'b0000;
      step();
      step();
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      press = 4'b1111;
      step();
      step();
      total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      total++; if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led); end
      total++; if (dropped !== 8'd0) begin bad++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
      rst   = 1'b0;
      press = 4'b0001;
      step();
      press = 4'b0000;
      step();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_release_grant got=%b exp=0001", grant); end
      total++; if (count !== 8'd1) begin bad++; $display("FAIL reset_release_count got=%0d exp=1", count); end
   endtask

   task automatic test_single_inc();
      int led_cnt;
      do_reset();
      press = 4'b0001;
      step();
      press = 4'b0000;
      led_cnt = (led === 1'b1) ? 1 : 0;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL inc_edge1_grant got=%b exp=0000", grant); end
      step();
      if (led === 1'b1) led_cnt++;
      total++; if (count !== 8'd1) begin bad++; $display("FAIL inc_count got=%0d exp=1", count); end
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL inc_grant got=%b exp=0001", grant); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (led === 1'b1) led_cnt++;
      end
      total++; if (led_cnt != 1) begin bad++; $display("FAIL inc_led_pulses got=%0d exp=1", led_cnt); end
      total++; if (count !== 8'd1) begin bad++; $display("FAIL inc_count_hold got=%0d exp=1", count); end
   endtask

   task automatic test_contention();
      logic [3:0] eg [4];
      logic [7:0] ec [4];
      do_reset();
      eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000;
      ec[0] = 8'd1;    ec[1] = 8'd0;    ec[2] = 8'd5;    ec[3] = 8'd0;
      press = 4'b1111;
      step();
      press = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (grant !== eg[i]) begin bad++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, grant, eg[i]); end
         total++; if (count !== ec[i]) begin bad++; $display("FAIL cont_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      end
      step();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL cont_idle_grant got=%b exp=0000", grant); end

      // Two ADDs leave count=10 with the pointer parked at requester 3.
      do_reset();
      press = 4'b0100;
      step();
      step();
      press = 4'b0000;
      step();
      total++; if (count !== 8'd10) begin bad++; $display("FAIL cont2_setup got=%0d exp=10", count); end
      eg[0] = 4'b1000; eg[1] = 4'b0001; eg[2] = 4'b0010; eg[3] = 4'b0100;
      ec[0] = 8'd0;    ec[1] = 8'd1;    ec[2] = 8'd0;    ec[3] = 8'd5;
      press = 4'b1111;
      step();
      press = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (grant !== eg[i]) begin bad++; $display("FAIL cont2_grant[%0d] got=%b exp=%b", i, grant, eg[i]); end
         total++; if (count !== ec[i]) begin bad++; $display("FAIL cont2_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      end
   endtask

   task automatic test_wrap_saturate();
      do_reset();
      press = 4'b0010;
      step();
      press = 4'b0000;
      step();
      total++; if (count !== 8'd255) begin bad++; $display("FAIL wrap_dec got=%0d exp=255", count); end
      total++; if (count_s !== 8'd0) begin bad++; $display("FAIL sat_dec got=%0d exp=0", count_s); end
      total++; if (grant_s !== 4'b0010) begin bad++; $display("FAIL sat_dec_grant got=%b exp=0010", grant_s); end

      do_reset();
      press = 4'b0100;
      for (int i = 0; i < 51; i++) step();
      press = 4'b0000;
      step();
      total++; if (count !== 8'd255) begin bad++; $display("FAIL wrap_add51 got=%0d exp=255", count); end
      total++; if (count_s !== 8'd255) begin bad++; $display("FAIL sat_add51 got=%0d exp=255", count_s); end

      press = 4'b0001;
      step();
      press = 4'b0000;
      step();
      total++; if (count !== 8'd0) begin bad++; $display("FAIL wrap_inc got=%0d exp=0", count); end
      total++; if (count_s !== 8'd255) begin bad++; $display("FAIL sat_inc got=%0d exp=255", count_s); end
      total++; if (grant_s !== 4'b0001) begin bad++; $display("FAIL sat_inc_grant got=%b exp=0001", grant_s); end

      press = 4'b0100;
      step();
      press = 4'b0000;
      step();
      total++; if (count !== 8'd5) begin bad++; $display("FAIL wrap_add got=%0d exp=5", count); end
      total++; if (count_s !== 8'd255) begin bad++; $display("FAIL sat_add got=%0d exp=255", count_s); end
      total++; if (led_s !== 1'b1) begin bad++; $display("FAIL sat_add_led got=%b exp=1", led_s); end
   endtask

   task automatic test_drop();
      do_reset();
      press = 4'b0101;
      step();
      press = 4'b0100;
      step();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL drop_grant0 got=%b exp=0001", grant); end
      total++; if (dropped !== 8'd1) begin bad++; $display("FAIL drop_count got=%0d exp=1", dropped); end
      press = 4'b0000;
      step();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL drop_grant2 got=%b exp=0100", grant); end
      total++; if (count !== 8'd6) begin bad++; $display("FAIL drop_value got=%0d exp=6", count); end
      step();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_single_add got=%b exp=0000", grant); end
      total++; if (dropped !== 8'd1) begin bad++; $display("FAIL drop_final got=%0d exp=1", dropped); end
   endtask

   task automatic test_reset_mid_op();
      int extra;
      do_reset();
      press = 4'b1110;
      step();
      press = 4'b0000;
      rst   = 1'b1;
      step();
      rst   = 1'b0;
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (grant !== 4'b0000) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL midrst_grants got=%0d exp=0", extra); end
      total++; if (count !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
      total++; if (dropped !== 8'd0) begin bad++; $display("FAIL midrst_dropped got=%0d exp=0", dropped); end
      press = 4'b1111;
      step();
      press = 4'b0000;
      step();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL midrst_ptr got=%b exp=0001", grant); end
   endtask

   task automatic test_repress_on_serve();
      int n_dec;
      do_reset();
      n_dec = 0;
      press = 4'b0010;
      step();
      step();
      if (grant === 4'b0010) n_dec++;
      total++; if (count !== 8'd255) begin bad++; $display("FAIL repress_first got=%0d exp=255", count); end
      press = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         if (grant === 4'b0010) n_dec++;
      end
      total++; if (n_dec != 2) begin bad++; $display("FAIL repress_grants got=%0d exp=2", n_dec); end
      total++; if (count !== 8'd254) begin bad++; $display("FAIL repress_count got=%0d exp=254", count); end
      total++; if (dropped !== 8'd0) begin bad++; $display("FAIL repress_dropped got=%0d exp=0", dropped); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      press = 4'b1111;
      step();
      total++; if (dropped !== 8'd0) begin bad++; $display("FAIL b2b_edge1 got=%0d exp=0", dropped); end
      step();
      step();
      total++; if (dropped !== 8'd6) begin bad++; $display("FAIL b2b_multi got=%0d exp=6", dropped); end
      for (int i = 0; i < 100; i++) step();
      total++; if (dropped !== 8'd255) begin bad++; $display("FAIL b2b_saturate got=%0d exp=255", dropped); end
      press = 4'b0000;
      step();
      total++; if (dropped !== 8'd255) begin bad++; $display("FAIL b2b_hold got=%0d exp=255", dropped); end
   endtask

   initial begin
      rst   = 1'b1;
      press = 4'b0000;
      test_reset();
      test_single_inc();
      test_contention();
      test_wrap_saturate();
      test_drop();
      test_reset_mid_op();
      test_repress_on_serve();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/press_event_arbiter.md
PRESS_EVENT_ARBITER -- requirements
Module: press_event_arbiter

Interface
REQ-001 SHALL have parameter STEP, default 8'd5, addend for op ADD.
REQ-002 SHALL have parameter WRAP, default 1; 1 = modulo-256 arithmetic, 0 = saturate at 0/255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port press  input  4  one-cycle press pulses from four debouncers; bit i = requester i.
REQ-006 SHALL have port count  output  8  shared counter value, registered.
REQ-007 SHALL have port grant  output  4  registered one-hot; bit i high one cycle when requester i's op executed.
REQ-008 SHALL have port led  output  1  registered; high one cycle per executed op (OR of grant).
REQ-009 SHALL have port dropped  output  8  registered count of lost press events, saturating at 255.

Function
REQ-010 SHALL map requesters to ops: 0 = INC (+1), 1 = DEC (-1), 2 = ADD (+STEP), 3 = CLEAR (to 0).
REQ-011 SHALL hold a 4-bit pending register; each edge: pend <= (pend & ~served) | press.
REQ-012 SHALL select at most one winner per edge from the current pend register, round-robin from pointer ptr (2 bits).
REQ-013 SHALL execute the winner's op on count at the same edge, assert grant[winner] and led, and set ptr <= winner+1 (mod 4).
REQ-014 SHALL keep count, ptr unchanged and grant = 0, led = 0 when pend = 0.
REQ-015 SHALL give latency of exactly 2 edges from a press sampled with empty pend and no contention to count/grant update.
REQ-016 SHALL, when press[i] arrives while pend[i] = 1 and i is not served that edge, leave pend[i] = 1 and increment dropped by 1.
REQ-017 SHALL, when press[i] arrives on the edge where i is served, set pend[i] = 1 again with no drop counted.
REQ-018 SHALL, when several press bits arrive on one edge, count drops independently per bit; dropped adds the number of dropped bits, saturating at 255.
REQ-019 SHALL, with WRAP = 1, wrap INC 255->0, DEC 0->255, ADD modulo 256.
REQ-020 SHALL, with WRAP = 0, saturate INC and ADD at 255 and DEC at 0; grant still asserts on a saturated op.
REQ-021 SHALL guarantee every pending requester is served within 4 edges (round-robin fairness).

Reset
REQ-022 SHALL, while rst = 1, set count = 0, grant = 0, led = 0, dropped = 0, pend = 0, ptr = 0, ignoring press.
REQ-023 SHALL discard pending events on reset mid-operation, with no grant issued for them after reset release.
REQ-024 SHALL sample press again on the first edge with rst = 0.

Structure
REQ-025 SHALL place the op enum (INC, DEC, ADD, CLEAR), NUM_REQ = 4 and the counter width 8 in a shared package press_arb_pkg.
REQ-026 SHALL implement arbitration in sub-module rr_arbiter4 (inputs req[3:0], ptr[1:0]; outputs one-hot gnt[3:0], valid), purely combinational.
REQ-027 SHALL keep all registers in press_event_arbiter; the debouncers remain external instances feeding press.

Verification
REQ-028 SHALL cover single INC: after reset, press = 0001 for one cycle -> count = 1, grant = 0001 on the second edge; led pulses once.
REQ-029 SHALL cover contention: press = 1111 for one cycle with count = 10, ptr = 0 -> grants 0001, 0010, 0100, 1000 on consecutive edges; count goes 11, 10, 15, 0.
REQ-030 SHALL cover wrap vs saturate: count = 255, INC -> 0 (WRAP = 1) or 255 (WRAP = 0); count = 0, DEC -> 255 or 0.
REQ-031 SHALL cover drop: press[2] on two consecutive edges while requester 0 is pending and ptr = 0 -> dropped = 1, exactly one ADD executed.
REQ-032 SHALL cover reset mid-operation: pend = 1110, rst high for one cycle -> no grants afterwards, count = 0, dropped = 0, ptr = 0.
REQ-033 SHALL cover re-press on serve: press[1] on the edge it is served -> two DEC grants total, dropped unchanged.
